// File: rtl/lc3b_types.sv
// Shared types for the L1 cache: line/offset types, FSM states, line width.
// Imported by cache_control and l1_cache.
package lc3b_types;

  localparam int LINE_W = 128;

  typedef logic [LINE_W-1:0] lc3b_cache_line;
  typedef logic [3:0]        lc3b_cache_offset;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL
  } cache_state_t;

endpackage

// File: rtl/cache_control.sv
// Cache FSM: IDLE / WRITEBACK / FILL, CPU response and pmem strobes,
// plus load enables for the hit-write and line-fill array updates.
module cache_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic write,
  input  logic hit,
  input  logic victim_dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_hit,
  output logic load_fill,
  output logic miss_start
);

  cache_state_t state, next;

  // state register; reset aborts any writeback or fill in flight
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  // next state and strobes, all decoded from the current state
  always_comb begin
    next       = state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    load_hit   = 1'b0;
    load_fill  = 1'b0;
    miss_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req && !reset) begin
          if (hit) begin
            mem_resp = 1'b1;
            load_hit = write;
          end else begin
            miss_start = 1'b1;
            next = victim_dirty ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) next = S_FILL;
      end
      S_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_fill = 1'b1;
          next = S_IDLE;
        end
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back write-allocate L1 cache with 128-bit line port.
// Optional `L1_CACHE_STATS_EN adds saturating hit/miss counters.
module l1_cache
  import lc3b_types::*;
#(
  parameter int SETS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          mem_addr,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [15:0]          mem_wdata,
  input  logic [1:0]           mem_byte_enable,
  output logic [15:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [15:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_W-1:0]    pmem_wdata,
`ifdef L1_CACHE_STATS_EN
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count,
`endif
  input  logic [LINE_W-1:0]    pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 16 - 4 - IW;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [2:0]    word;
  logic          unused;

  assign idx    = mem_addr[4 +: IW];
  assign tag    = mem_addr[15 -: TW];
  assign word   = mem_addr[3:1];
  assign unused = mem_addr[0];

  lc3b_cache_line  data_q [SETS];
  logic [TW-1:0]   tag_q  [SETS];
  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;

  logic hit, victim_dirty;
  logic load_hit, load_fill, miss_start;
  lc3b_cache_line line, merged;

  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  cache_control u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .req          (mem_read | mem_write),
    .write        (mem_write),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .pmem_resp    (pmem_resp),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .load_hit     (load_hit),
    .load_fill    (load_fill),
    .miss_start   (miss_start)
  );

  // selected line and its byte-merged copy for write hits
  always_comb begin
    line   = data_q[idx];
    merged = line;
    if (mem_byte_enable[0])
      merged[{word, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1])
      merged[{word, 4'h8} +: 8] = mem_wdata[15:8];
  end

  // valid/dirty bits; a fill installs clean, a write hit marks dirty
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (load_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // data and tag arrays, no reset needed
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_fill) begin
        data_q[idx] <= pmem_rdata;
        tag_q[idx]  <= tag;
      end else if (load_hit) begin
        data_q[idx] <= merged;
      end
    end
  end

  assign mem_rdata  = mem_resp ? line[{word, 4'h0} +: 16] : 16'h0;
  assign pmem_wdata = pmem_write ? line : '0;

  // victim address while writing back, request address while filling
  always_comb begin
    pmem_address = 16'h0;
    if (pmem_write)
      pmem_address = {tag_q[idx], idx, 4'h0};
    else if (pmem_read)
      pmem_address = {tag, idx, 4'h0};
  end

`ifdef L1_CACHE_STATS_EN
  logic missed_q;

  // saturating counters; responses after a miss are not hits
  always_ff @(posedge clk) begin
    if (reset) begin
      missed_q   <= 1'b0;
      hit_count  <= 16'h0;
      miss_count <= 16'h0;
    end else begin
      if (miss_start) begin
        missed_q <= 1'b1;
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'h1;
      end
      if (mem_resp) begin
        missed_q <= 1'b0;
        if (!missed_q && hit_count != 16'hFFFF)
          hit_count <= hit_count + 16'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Scoreboard bench for l1_cache: flat CPU-view memory model plus a
// per-set residency model predict read data, hit latency and traffic.
module tb_l1_cache;

  localparam int SETS = 8;
  localparam int IW   = $clog2(SETS);

  logic clk = 1'b0;
  logic reset;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pmem_address;
  logic mem_read, mem_write, mem_resp;
  logic [1:0] mem_byte_enable;
  logic pmem_read, pmem_write, pmem_resp;
  logic [127:0] pmem_rdata, pmem_wdata;
`ifdef L1_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  l1_cache #(.SETS(SETS)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
`ifdef L1_CACHE_STATS_EN
    .hit_count       (hit_count),
    .miss_count      (miss_count),
`endif
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int fails  = 0;

  logic [127:0] pmem_mem [logic [15:0]];
  logic [15:0]  cpu_mem  [logic [15:0]];
  bit           m_valid [SETS];
  bit           m_dirty [SETS];
  int           m_tag   [SETS];

  int exp_wb = 0, exp_fill = 0;
  int wb_count = 0, fill_count = 0;
  logic [15:0]  last_wb_addr, last_fill_addr;
  logic [127:0] last_wb_data;
  bit hold = 0;
  bit req_active = 0;
  int lat = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [15:0] a);
    logic [15:0] k;
    k = a & 16'hFFFE;
    return {k[7:0], k[15:8]} ^ 16'h3C5A;
  endfunction

  function automatic logic [127:0] mk_line(input logic [15:0] base);
    logic [127:0] l;
    for (int w = 0; w < 8; w++)
      l[16*w +: 16] = init_word(base + 16'(2 * w));
    return l;
  endfunction

  function automatic logic [127:0] get_line(input logic [15:0] a);
    if (pmem_mem.exists(a)) return pmem_mem[a];
    return mk_line(a);
  endfunction

  function automatic logic [15:0] cpu_word(input logic [15:0] a);
    if (cpu_mem.exists(a)) return cpu_mem[a];
    return init_word(a);
  endfunction

  // physical memory responder with random latency
  initial begin
    int wcnt, plat;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    wcnt = 0;
    plat = 0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        wcnt = 0;
      end else if (!reset && !hold && (pmem_read || pmem_write)) begin
        check("pmem_excl", {31'b0, pmem_read & pmem_write}, 0);
        check("pmem_align", {28'b0, pmem_address[3:0]}, 0);
        if (wcnt >= plat) begin
          if (pmem_write) begin
            pmem_mem[pmem_address] = pmem_wdata;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            wb_count++;
          end else begin
            pmem_rdata = get_line(pmem_address);
            last_fill_addr = pmem_address;
            fill_count++;
          end
          pmem_resp = 1'b1;
          plat = $urandom_range(0, 2);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // response monitor: pops the scoreboard on every mem_resp
  always @(negedge clk) begin
    if (!reset && mem_resp) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp: got resp with empty queue, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.wr) check("rdata", {16'b0, mem_rdata}, {16'b0, mon_e.data});
        check("hit_latency", {31'b0, lat == 0}, {31'b0, mon_e.hit});
        if (!mon_e.hit) check("miss_min_latency", {31'b0, lat >= 2}, 1);
      end
    end else if (req_active) begin
      lat++;
    end
  end

  task automatic do_req(input logic [15:0] a, input logic wr,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic both);
    int idx, tg, n;
    logic h;
    logic [15:0] key, cur;
    exp_t e;
    idx = int'(a[15:4]) % SETS;
    tg  = int'(a) >> (4 + IW);
    h = m_valid[idx] && (m_tag[idx] == tg);
    if (!h) begin
      if (m_valid[idx] && m_dirty[idx]) exp_wb++;
      exp_fill++;
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 0;
    end
    key = a & 16'hFFFE;
    cur = cpu_word(key);
    if (wr) begin
      m_dirty[idx] = 1;
      if (be[0]) cur[7:0]  = wd[7:0];
      if (be[1]) cur[15:8] = wd[15:8];
      cpu_mem[key] = cur;
    end
    e.wr = wr;
    e.data = cur;
    e.hit = h;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    mem_addr = a;
    mem_write = wr;
    mem_read = !wr || both;
    mem_wdata = wd;
    mem_byte_enable = be;
    req_active = 1;
    lat = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_resp) break;
      n++;
      if (n > 200) begin
        $display("FAIL req_timeout: got no resp for %h, expected resp", a);
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    mem_read = 0;
    mem_write = 0;
    req_active = 0;
  endtask

  initial begin
    logic [127:0] l;
    int wb0, n;
    bit seen;
    reset = 1;
    mem_addr = 0;
    mem_read = 0;
    mem_write = 0;
    mem_wdata = 0;
    mem_byte_enable = 0;
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_resp", {31'b0, mem_resp}, 0);
    check("rst_pmem_read", {31'b0, pmem_read}, 0);
    check("rst_pmem_write", {31'b0, pmem_write}, 0);
    check("rst_pmem_address", {16'b0, pmem_address}, 0);
    check("rst_pmem_wdata_or", {31'b0, |pmem_wdata}, 0);
    check("rst_mem_rdata", {16'b0, mem_rdata}, 0);
    @(posedge clk);
    #1 reset = 0;

    l = mk_line(16'h1230);
    l[47:32] = 16'hBEEF;
    pmem_mem[16'h1230] = l;
    cpu_mem[16'h1234] = 16'hBEEF;

    do_req(16'h1234, 0, 0, 0, 0);
    check("fill_addr_1230", {16'b0, last_fill_addr}, 32'h1230);
    do_req(16'h1234, 0, 0, 0, 0);
    do_req(16'h1234, 0, 0, 0, 0);
    do_req(16'h1235, 0, 0, 0, 0);
`ifdef L1_CACHE_STATS_EN
    check("miss_count", {16'b0, miss_count}, 1);
    check("hit_count", {16'b0, hit_count}, 3);
`endif

    do_req(16'h1234, 1, 16'hAA55, 2'b01, 0);
    do_req(16'h1234, 0, 0, 0, 0);

    wb0 = wb_count;
    do_req(16'h9234, 0, 0, 0, 0);
    check("wb_count_dirty", wb_count, wb0 + 1);
    check("wb_addr", {16'b0, last_wb_addr}, 32'h1230);
    check("wb_word2", {16'b0, last_wb_data[47:32]}, 32'hBE55);
    check("fill_addr_9230", {16'b0, last_fill_addr}, 32'h9230);

    wb0 = wb_count;
    do_req(16'h1234, 0, 0, 0, 0);
    check("clean_miss_no_wb", wb_count, wb0);
    check("fill_addr_clean", {16'b0, last_fill_addr}, 32'h1230);

    hold = 1;
    @(posedge clk);
    #1;
    mem_addr = 16'h5678;
    mem_read = 1;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = pmem_read;
      n++;
    end
    check("fill_started", {31'b0, seen}, 1);
    @(posedge clk);
    #1;
    reset = 1;
    mem_read = 0;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("abort_pmem_read", {31'b0, pmem_read}, 0);
    check("abort_pmem_write", {31'b0, pmem_write}, 0);
    hold = 0;
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    do_req(16'h5678, 0, 0, 0, 0);
    do_req(16'h1234, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      a = 16'h4000 | 16'($urandom_range(0, 3) << 7)
                   | 16'($urandom_range(0, 7) << 4)
                   | 16'($urandom_range(0, 15));
      do_req(a, 1'($urandom_range(0, 1)), 16'($urandom),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    check("total_writebacks", wb_count, exp_wb);
    check("total_fills", fill_count, exp_fill);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
